fdtd_step_seq: RTL and testbench
================================

Name: fdtd_step_seq

Overview:
Time-step sequencer directly upstream of the FDTD calculation controller; drives its calc_Hy_flg / calc_Ez_flg / calc_src_flg start inputs.
Per time step it issues Hy update, then Ez update, then source injection. It uses the falling edge of the controller's wrt_Hy_start / wrt_Ez_start / wrt_src_start as the phase-done indication.
It counts completed steps up to a programmed total, reports done, and has a watchdog per phase.

Parameters:
STEP_CNT_WIDTH, 16, width of step counter and time_steps_i
TIMEOUT_CYCLES, 4096, max cycles allowed in any WAIT_* state
TIMEOUT_WIDTH, 13, watchdog counter width; must satisfy 2^TIMEOUT_WIDTH > TIMEOUT_CYCLES

Ports:
CLK  in  1  clock
RST_N  in  1  reset
start_i  in  1  run request, sampled only in IDLE
abort_i  in  1  synchronous abort, any state
time_steps_i  in  STEP_CNT_WIDTH  total steps, latched on accepted start
wrt_Hy_start_i  in  1  controller Hy write-back strobe (level)
wrt_Ez_start_i  in  1  controller Ez write-back strobe (level)
wrt_src_start_i  in  1  controller src write-back strobe (level)
calc_Hy_flg_o  out  1  one-cycle Hy phase start pulse
calc_Ez_flg_o  out  1  one-cycle Ez phase start pulse
calc_src_flg_o  out  1  one-cycle src phase start pulse
busy_o  out  1  high whenever not in IDLE
done_o  out  1  one-cycle pulse on run completion
step_cnt_o  out  STEP_CNT_WIDTH  completed steps in the current/last run
phase_o  out  2  0 idle, 1 Hy, 2 Ez, 3 src
err_timeout_o  out  1  sticky watchdog error, cleared on the next accepted start

Behaviour:
- Clock and reset: reset RST_N, asynchronous, active-low; clock CLK. All outputs are registered.
- Reset values: all outputs 0; state IDLE; latched step total 0; watchdog 0; edge-detect history 0.
- States: IDLE, ISSUE_HY, WAIT_HY, ISSUE_EZ, WAIT_EZ, ISSUE_SRC, WAIT_SRC, FINISH.
- IDLE:
  - start_i=1 and abort_i=0: latch time_steps_i, clear step_cnt_o and err_timeout_o.
  - Then go to ISSUE_HY, or to FINISH if time_steps_i==0.
  - start_i while busy_o=1 is ignored.
- ISSUE_x: the matching calc_*_flg_o is high for exactly this one cycle, then the FSM goes to WAIT_x unconditionally.
- Start latency: start_i sampled at edge N gives calc_Hy_flg_o high during cycle N+1 only.
- WAIT_x: phase done is prev(wrt_x_start_i)=1 and wrt_x_start_i=0, using a registered history bit.
  - Done detected at edge M: next flag high in cycle M+1.
  - WAIT_HY goes to ISSUE_EZ; WAIT_EZ goes to ISSUE_SRC.
  - WAIT_SRC: step_cnt_o+1. If the new value equals the latched total, go to FINISH; else go to ISSUE_HY.
- History bits update every cycle in all states, so a stale high level entering WAIT still needs a true falling edge.
- FINISH: done_o=1 for this cycle, then IDLE. busy_o is high in FINISH and falls one cycle after done_o.
- Watchdog:
  - Cleared on entry to each WAIT_x; increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES-1 without done: err_timeout_o=1, go to IDLE, no done_o, step_cnt_o holds its value.
  - Done detected in the same cycle as the timeout: done wins.
- abort_i=1: go to IDLE at the next edge. No flags, no done_o; step_cnt_o holds; err_timeout_o unaffected. abort_i wins over start_i.
- Step counter: compares on equality. A total of 2^STEP_CNT_WIDTH-1 is legal, and the counter never wraps within a run.
- phase_o: set on entry to ISSUE_x and held through WAIT_x; 0 in IDLE and FINISH.
- Reset mid-run: immediate return to reset values, with no pulse on any flag output.

Decomposition:
- Shared package fdtd_pkg: state enum typedef (logic [3:0]) and phase encodings PH_IDLE/PH_HY/PH_EZ/PH_SRC.
- One sub-module, fdtd_phase_wdog: counter with clear/enable inputs, parameterised by TIMEOUT_CYCLES and TIMEOUT_WIDTH, and an expired output.
- Falling-edge detection stays inline.

Test Plan:
- time_steps_i=3, controller model drops each wrt_*_start 5 cycles after its flag, after being high 2 cycles -> flag order HY,EZ,SRC repeated 3 times; each flag exactly 1 cycle wide; step_cnt_o=3; one done_o pulse; 9 flags total.
- time_steps_i=0, start_i pulse -> no flags; done_o high in cycle N+2 (N+1 is FINISH registered output); busy_o high for exactly 1 cycle.
- wrt_Ez_start_i never falls, TIMEOUT_CYCLES=16 -> err_timeout_o=1 after 15 WAIT_EZ cycles, back to IDLE, no done_o; next start_i clears err_timeout_o.
- abort_i in WAIT_EZ of step 2 of 5 -> IDLE next cycle, step_cnt_o=1, no done_o, no further flags; a later start_i runs a fresh 5-step sequence.
- start_i and abort_i high together in IDLE -> stays IDLE, busy_o=0; start_i pulsed mid-run -> ignored, and the sequence and step count are unchanged.
- RST_N asserted while calc_Ez_flg_o=1 -> all outputs 0 immediately (asynchronous reset); after release, no spurious flag.

Source files
------------

// File: rtl/fdtd_pkg.sv
// Shared types for the FDTD time-step sequencer: FSM state encoding and phase codes.
package fdtd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ISSUE_HY  = 4'd1,
    ST_WAIT_HY   = 4'd2,
    ST_ISSUE_EZ  = 4'd3,
    ST_WAIT_EZ   = 4'd4,
    ST_ISSUE_SRC = 4'd5,
    ST_WAIT_SRC  = 4'd6,
    ST_FINISH    = 4'd7
  } state_t;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_HY   = 2'd1;
  localparam logic [1:0] PH_EZ   = 2'd2;
  localparam logic [1:0] PH_SRC  = 2'd3;

endpackage

// File: rtl/fdtd_phase_wdog.sv
// Per-phase watchdog: counts cycles spent waiting for a phase to finish.
// expired fires in the wait cycle whose increment would bring the count to TIMEOUT_CYCLES-1,
// so a phase that never completes leaves WAIT after TIMEOUT_CYCLES-1 cycles.
module fdtd_phase_wdog #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMEOUT_WIDTH  = 13
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TIMEOUT_WIDTH-1:0] LAST_COUNT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 2);

  logic [TIMEOUT_WIDTH-1:0] count;

  // Count wait cycles; cleared while the phase is being issued.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en && (count == LAST_COUNT);

endmodule

// File: rtl/fdtd_step_seq.sv
// Time-step sequencer for the FDTD calculation controller: per step it issues Hy, Ez and
// source phases, waits for each write-back strobe to fall, counts steps and flags timeouts.
module fdtd_step_seq
  import fdtd_pkg::*;
#(
  parameter int STEP_CNT_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMEOUT_WIDTH  = 13
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [STEP_CNT_WIDTH-1:0] time_steps_i,
  input  logic                      wrt_Hy_start_i,
  input  logic                      wrt_Ez_start_i,
  input  logic                      wrt_src_start_i,
  output logic                      calc_Hy_flg_o,
  output logic                      calc_Ez_flg_o,
  output logic                      calc_src_flg_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [STEP_CNT_WIDTH-1:0] step_cnt_o,
  output logic [1:0]                phase_o,
  output logic                      err_timeout_o
);

  state_t                    state;
  logic [STEP_CNT_WIDTH-1:0] total_steps;
  logic [STEP_CNT_WIDTH-1:0] step_next;
  logic                      hy_q, ez_q, src_q;
  logic                      fall_hy, fall_ez, fall_src;
  logic                      wd_clr, wd_en, wd_expired;

  assign fall_hy   = hy_q  & ~wrt_Hy_start_i;
  assign fall_ez   = ez_q  & ~wrt_Ez_start_i;
  assign fall_src  = src_q & ~wrt_src_start_i;
  assign step_next = step_cnt_o + 1'b1;

  assign wd_clr = (state == ST_ISSUE_HY) || (state == ST_ISSUE_EZ) || (state == ST_ISSUE_SRC);
  assign wd_en  = (state == ST_WAIT_HY)  || (state == ST_WAIT_EZ)  || (state == ST_WAIT_SRC);

  fdtd_phase_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
  ) u_wdog (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // Strobe history, updated every cycle so a stale high level still needs a real falling edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hy_q  <= 1'b0;
      ez_q  <= 1'b0;
      src_q <= 1'b0;
    end else begin
      hy_q  <= wrt_Hy_start_i;
      ez_q  <= wrt_Ez_start_i;
      src_q <= wrt_src_start_i;
    end
  end

  // Sequencer FSM with registered outputs; phase flags are raised together with the ISSUE state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state          <= ST_IDLE;
      total_steps    <= '0;
      calc_Hy_flg_o  <= 1'b0;
      calc_Ez_flg_o  <= 1'b0;
      calc_src_flg_o <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      step_cnt_o     <= '0;
      phase_o        <= PH_IDLE;
      err_timeout_o  <= 1'b0;
    end else begin
      calc_Hy_flg_o  <= 1'b0;
      calc_Ez_flg_o  <= 1'b0;
      calc_src_flg_o <= 1'b0;
      busy_o         <= (state != ST_IDLE);
      done_o         <= (state == ST_FINISH) && !abort_i;
      if (abort_i) begin
        state   <= ST_IDLE;
        phase_o <= PH_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_i && !busy_o) begin
              total_steps   <= time_steps_i;
              step_cnt_o    <= '0;
              err_timeout_o <= 1'b0;
              if (time_steps_i == '0) begin
                state <= ST_FINISH;
              end else begin
                state         <= ST_ISSUE_HY;
                calc_Hy_flg_o <= 1'b1;
                phase_o       <= PH_HY;
              end
            end
          end
          ST_ISSUE_HY:  state <= ST_WAIT_HY;
          ST_ISSUE_EZ:  state <= ST_WAIT_EZ;
          ST_ISSUE_SRC: state <= ST_WAIT_SRC;
          ST_WAIT_HY: begin
            if (fall_hy) begin
              state         <= ST_ISSUE_EZ;
              calc_Ez_flg_o <= 1'b1;
              phase_o       <= PH_EZ;
            end else if (wd_expired) begin
              state         <= ST_IDLE;
              phase_o       <= PH_IDLE;
              err_timeout_o <= 1'b1;
            end
          end
          ST_WAIT_EZ: begin
            if (fall_ez) begin
              state          <= ST_ISSUE_SRC;
              calc_src_flg_o <= 1'b1;
              phase_o        <= PH_SRC;
            end else if (wd_expired) begin
              state         <= ST_IDLE;
              phase_o       <= PH_IDLE;
              err_timeout_o <= 1'b1;
            end
          end
          ST_WAIT_SRC: begin
            if (fall_src) begin
              step_cnt_o <= step_next;
              if (step_next == total_steps) begin
                state   <= ST_FINISH;
                phase_o <= PH_IDLE;
              end else begin
                state         <= ST_ISSUE_HY;
                calc_Hy_flg_o <= 1'b1;
                phase_o       <= PH_HY;
              end
            end else if (wd_expired) begin
              state         <= ST_IDLE;
              phase_o       <= PH_IDLE;
              err_timeout_o <= 1'b1;
            end
          end
          ST_FINISH: begin
            state   <= ST_IDLE;
            phase_o <= PH_IDLE;
          end
          default: begin
            state   <= ST_IDLE;
            phase_o <= PH_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fdtd_step_seq.sv
// Directed bench for fdtd_step_seq: table-driven runs plus hand-written corner sequences.
module tb_fdtd_step_seq;

  localparam int SW = 16;
  localparam int TC = 16;
  localparam int TW = 5;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [SW-1:0] time_steps_i = '0;
  logic          wrt_Hy_start_i = 1'b0;
  logic          wrt_Ez_start_i = 1'b0;
  logic          wrt_src_start_i = 1'b0;
  logic          calc_Hy_flg_o, calc_Ez_flg_o, calc_src_flg_o;
  logic          busy_o, done_o, err_timeout_o;
  logic [SW-1:0] step_cnt_o;
  logic [1:0]    phase_o;

  int checks = 0;
  int failures = 0;

  int hy_n = 0, ez_n = 0, src_n = 0, done_n = 0, order_err = 0, width_err = 0;
  int s_hy, s_ez, s_src, s_done, s_order, s_width;
  int last_flag = 0;
  logic ph_hy = 1'b0, ph_ez = 1'b0, ph_src = 1'b0;
  bit ez_force = 1'b0;
  int hy_t = 0, ez_t = 0, src_t = 0;

  typedef struct {
    logic [SW-1:0] steps;
    int            exp_flags;
    int            exp_done;
    logic [SW-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[4];

  always #5 CLK = ~CLK;

  fdtd_step_seq #(
    .STEP_CNT_WIDTH (SW),
    .TIMEOUT_CYCLES (TC),
    .TIMEOUT_WIDTH  (TW)
  ) dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .time_steps_i    (time_steps_i),
    .wrt_Hy_start_i  (wrt_Hy_start_i),
    .wrt_Ez_start_i  (wrt_Ez_start_i),
    .wrt_src_start_i (wrt_src_start_i),
    .calc_Hy_flg_o   (calc_Hy_flg_o),
    .calc_Ez_flg_o   (calc_Ez_flg_o),
    .calc_src_flg_o  (calc_src_flg_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .step_cnt_o      (step_cnt_o),
    .phase_o         (phase_o),
    .err_timeout_o   (err_timeout_o)
  );

  // Controller model: each strobe rises two cycles after its flag, stays high two cycles, then drops.
  always @(negedge CLK) begin
    if (!RST_N) begin
      hy_t = 0; ez_t = 0; src_t = 0;
      wrt_Hy_start_i = 1'b0; wrt_Ez_start_i = 1'b0; wrt_src_start_i = 1'b0;
    end else begin
      hy_t  = calc_Hy_flg_o  ? 1 : ((hy_t  != 0) ? hy_t  + 1 : 0);
      ez_t  = calc_Ez_flg_o  ? 1 : ((ez_t  != 0) ? ez_t  + 1 : 0);
      src_t = calc_src_flg_o ? 1 : ((src_t != 0) ? src_t + 1 : 0);
      if (hy_t  >= 6) hy_t  = 0;
      if (ez_t  >= 6) ez_t  = 0;
      if (src_t >= 6) src_t = 0;
      wrt_Hy_start_i  = (hy_t == 3) || (hy_t == 4);
      wrt_Ez_start_i  = ez_force || (ez_t == 3) || (ez_t == 4);
      wrt_src_start_i = (src_t == 3) || (src_t == 4);
    end
  end

  // Flag monitor: counts pulses, checks HY->EZ->SRC order and one-cycle width.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (calc_Hy_flg_o) begin
        hy_n++;
        if (last_flag == 1 || last_flag == 2) order_err++;
        last_flag = 1;
        if (ph_hy) width_err++;
      end
      if (calc_Ez_flg_o) begin
        ez_n++;
        if (last_flag != 1) order_err++;
        last_flag = 2;
        if (ph_ez) width_err++;
      end
      if (calc_src_flg_o) begin
        src_n++;
        if (last_flag != 2) order_err++;
        last_flag = 3;
        if (ph_src) width_err++;
      end
      if (done_o) done_n++;
    end
    ph_hy  = calc_Hy_flg_o;
    ph_ez  = calc_Ez_flg_o;
    ph_src = calc_src_flg_o;
  end

  // Global safety net so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [SW-1:0] steps, input bit with_abort);
    @(negedge CLK);
    last_flag    = 0;
    start_i      = 1'b1;
    abort_i      = with_abort;
    time_steps_i = steps;
    @(negedge CLK);
    start_i = 1'b0;
    abort_i = 1'b0;
  endtask

  task automatic snap();
    s_hy = hy_n; s_ez = ez_n; s_src = src_n; s_done = done_n; s_order = order_err; s_width = width_err;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic waitDone(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic waitEzFlag(input int budget, input int nth, output bit seen);
    int cnt;
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (RST_N && calc_Ez_flg_o) cnt++;
      if (cnt == nth) begin
        seen = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    bit seen;
    vecs[0] = '{steps: 16'd1, exp_flags: 1, exp_done: 1, exp_cnt: 16'd1};
    vecs[1] = '{steps: 16'd3, exp_flags: 3, exp_done: 1, exp_cnt: 16'd3};
    vecs[2] = '{steps: 16'd4, exp_flags: 4, exp_done: 1, exp_cnt: 16'd4};
    vecs[3] = '{steps: 16'd2, exp_flags: 2, exp_done: 1, exp_cnt: 16'd2};

    // Reset state
    idle(3);
    checkOutput("reset_flags", {calc_Hy_flg_o, calc_Ez_flg_o, calc_src_flg_o}, 0);
    checkOutput("reset_busy_done_err", {busy_o, done_o, err_timeout_o}, 0);
    checkOutput("reset_step_cnt", step_cnt_o, 0);
    checkOutput("reset_phase", phase_o, 0);
    RST_N = 1'b1;
    idle(2);

    // Table-driven complete runs
    foreach (vecs[k]) begin
      snap();
      applyStimulus(vecs[k].steps, 1'b0);
      checkOutput("start_latency_hy", calc_Hy_flg_o, 1);
      checkOutput("phase_hy_on_issue", phase_o, 1);
      @(negedge CLK);
      checkOutput("hy_flag_one_cycle", calc_Hy_flg_o, 0);
      checkOutput("busy_during_run", busy_o, 1);
      waitDone(40 * vecs[k].steps + 20, seen);
      checkOutput("run_done_seen", seen, 1);
      checkOutput("run_step_cnt", step_cnt_o, vecs[k].exp_cnt);
      checkOutput("phase_idle_at_done", phase_o, 0);
      idle(12);
      checkOutput("run_hy_flags", hy_n - s_hy, vecs[k].exp_flags);
      checkOutput("run_ez_flags", ez_n - s_ez, vecs[k].exp_flags);
      checkOutput("run_src_flags", src_n - s_src, vecs[k].exp_flags);
      checkOutput("run_done_pulses", done_n - s_done, vecs[k].exp_done);
      checkOutput("run_flag_order", order_err - s_order, 0);
      checkOutput("run_flag_width", width_err - s_width, 0);
      checkOutput("run_busy_after", busy_o, 0);
    end

    // Zero steps: FINISH in N+1, done_o and busy_o in N+2 only
    snap();
    applyStimulus(16'd0, 1'b0);
    checkOutput("zero_n1_done", done_o, 0);
    checkOutput("zero_n1_busy", busy_o, 0);
    @(negedge CLK);
    checkOutput("zero_n2_done", done_o, 1);
    checkOutput("zero_n2_busy", busy_o, 1);
    @(negedge CLK);
    checkOutput("zero_n3_done", done_o, 0);
    checkOutput("zero_n3_busy", busy_o, 0);
    idle(3);
    checkOutput("zero_no_flags", (hy_n - s_hy) + (ez_n - s_ez) + (src_n - s_src), 0);
    checkOutput("zero_done_pulses", done_n - s_done, 1);

    // Watchdog: Ez strobe held high (stale level) so no falling edge ever arrives
    ez_force = 1'b1;
    idle(2);
    snap();
    applyStimulus(16'd2, 1'b0);
    waitEzFlag(60, 1, seen);
    checkOutput("tmo_ez_flag_seen", seen, 1);
    repeat (TC - 1) @(negedge CLK);
    checkOutput("tmo_err_before", err_timeout_o, 0);
    checkOutput("tmo_phase_waiting", phase_o, 2);
    @(negedge CLK);
    checkOutput("tmo_err_set", err_timeout_o, 1);
    checkOutput("tmo_phase_idle", phase_o, 0);
    idle(5);
    checkOutput("tmo_no_done", done_n - s_done, 0);
    checkOutput("tmo_no_src", src_n - s_src, 0);
    checkOutput("tmo_step_cnt", step_cnt_o, 0);
    checkOutput("tmo_busy_low", busy_o, 0);
    checkOutput("tmo_err_sticky", err_timeout_o, 1);
    ez_force = 1'b0;
    idle(4);
    snap();
    applyStimulus(16'd1, 1'b0);
    checkOutput("tmo_err_cleared", err_timeout_o, 0);
    waitDone(60, seen);
    checkOutput("tmo_recover_done", seen, 1);
    checkOutput("tmo_recover_cnt", step_cnt_o, 1);
    idle(12);

    // Abort in WAIT_EZ of step 2 of 5, then a fresh 5-step run
    snap();
    applyStimulus(16'd5, 1'b0);
    waitEzFlag(100, 2, seen);
    checkOutput("abort_second_ez_seen", seen, 1);
    @(negedge CLK);
    checkOutput("abort_in_wait_ez", phase_o, 2);
    abort_i = 1'b1;
    @(negedge CLK);
    abort_i = 1'b0;
    checkOutput("abort_phase_idle", phase_o, 0);
    checkOutput("abort_step_cnt", step_cnt_o, 1);
    idle(20);
    checkOutput("abort_no_done", done_n - s_done, 0);
    checkOutput("abort_hy_flags", hy_n - s_hy, 2);
    checkOutput("abort_src_flags", src_n - s_src, 1);
    checkOutput("abort_busy_low", busy_o, 0);
    checkOutput("abort_cnt_holds", step_cnt_o, 1);
    snap();
    applyStimulus(16'd5, 1'b0);
    waitDone(220, seen);
    checkOutput("fresh_done_seen", seen, 1);
    checkOutput("fresh_step_cnt", step_cnt_o, 5);
    idle(12);
    checkOutput("fresh_src_flags", src_n - s_src, 5);
    checkOutput("fresh_order", order_err - s_order, 0);

    // start_i and abort_i together in IDLE: abort wins
    snap();
    applyStimulus(16'd3, 1'b1);
    checkOutput("startabort_busy", busy_o, 0);
    checkOutput("startabort_hy", calc_Hy_flg_o, 0);
    idle(3);
    checkOutput("startabort_busy_later", busy_o, 0);
    checkOutput("startabort_no_flags", hy_n - s_hy, 0);

    // start_i pulsed mid-run is ignored
    snap();
    applyStimulus(16'd2, 1'b0);
    idle(6);
    start_i      = 1'b1;
    time_steps_i = 16'd7;
    @(negedge CLK);
    start_i = 1'b0;
    waitDone(100, seen);
    checkOutput("midstart_done_seen", seen, 1);
    checkOutput("midstart_step_cnt", step_cnt_o, 2);
    idle(12);
    checkOutput("midstart_hy_flags", hy_n - s_hy, 2);
    checkOutput("midstart_order", order_err - s_order, 0);
    checkOutput("midstart_done_pulses", done_n - s_done, 1);

    // Asynchronous reset while calc_Ez_flg_o is high
    applyStimulus(16'd3, 1'b0);
    waitEzFlag(60, 1, seen);
    checkOutput("rst_ez_flag_seen", seen, 1);
    #2;
    RST_N = 1'b0;
    #1;
    checkOutput("rst_async_flags", {calc_Hy_flg_o, calc_Ez_flg_o, calc_src_flg_o}, 0);
    checkOutput("rst_async_others", {busy_o, done_o, err_timeout_o, phase_o, step_cnt_o}, 0);
    @(negedge CLK);
    snap();
    @(negedge CLK);
    RST_N = 1'b1;
    idle(10);
    checkOutput("rst_no_spurious_flags", (hy_n - s_hy) + (ez_n - s_ez) + (src_n - s_src), 0);
    checkOutput("rst_busy_low", busy_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
